vblank_write_arbiter: RTL and testbench

- Schedules game-logic updates into the shared game-state RAM so they never collide with pixel rendering.
- Opens a write window on each vertical sync pulse and round-robin arbitrates NUM_REQ requesters for the RAM write port in bursts.
- Outside the window, the RAM address port belongs to the render pipeline.
- Sits between the VGA timing generator (vsync/active) and the game-state RAM.

---
 rtl/vblank_write_arbiter.sv | 179 +++++++++++++++++
 tb/tb_vblank_write_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vblank_write_arbiter.sv
// Vertical-blank write arbiter: opens a RAM write window on each vsync fall and
// round-robin bursts NUM_REQ requesters into it. Optional stats: VBLANK_OVERRUN_STATS_EN.
module vblank_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int BURST_LEN = 8,
   parameter int FCNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      vsync,
   input  logic                      active,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   input  logic [ADDR_W-1:0]         render_addr,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_we,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic                      window,
   output logic                      frame_tick,
   output logic [FCNT_W-1:0]         frame_count
`ifdef VBLANK_OVERRUN_STATS_EN
   ,
   output logic                      overrun,
   output logic [NUM_REQ-1:0]        overrun_mask,
   output logic [FCNT_W-1:0]         overrun_count
`endif
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int BCNT_W = 8;

   typedef enum logic [1:0] {IDLE, ARB, BURST} state_t;

   state_t              state_reg, state_next;
   logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
   logic [IDX_W-1:0]    gnt_idx_reg, gnt_idx_next;
   logic [IDX_W-1:0]    pick_idx, inc_idx;
   logic                pick_valid;
   logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
   logic [BCNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
   logic                vsync_d_reg;
   logic                frame_tick_reg;
   logic [FCNT_W-1:0]   frame_count_reg;
   logic                fall, rise, in_win, timing_err, write_en, open_win, close_win;
   logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
   logic [DATA_W-1:0]   data_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
         assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   assign fall       = vsync_d_reg & ~vsync;
   assign rise       = ~vsync_d_reg & vsync;
   assign in_win     = (state_reg != IDLE);
   assign timing_err = in_win & active;
   assign close_win  = in_win & (rise | active);
   // gnt_reg is zero outside BURST, so this alone qualifies the write
   assign write_en   = ~active & (|(gnt_reg & req));
   assign inc_idx    = (gnt_idx_reg == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx_reg + 1'b1;

   // Round-robin pick: lowest offset from the pointer wins
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = rr_ptr_reg;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         int j;
         j = int'(rr_ptr_reg) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req[j]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(j);
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      gnt_next       = gnt_reg;
      gnt_idx_next   = gnt_idx_reg;
      rr_ptr_next    = rr_ptr_reg;
      burst_cnt_next = burst_cnt_reg;
      open_win       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (fall) begin
               state_next = ARB;
               open_win   = 1'b1;
            end
         end
         ARB: begin
            if (pick_valid) begin
               state_next     = BURST;
               gnt_next       = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
               gnt_idx_next   = pick_idx;
               burst_cnt_next = '0;
            end
         end
         BURST: begin
            if (write_en) burst_cnt_next = burst_cnt_reg + 1'b1;
            if (!req[gnt_idx_reg] ||
                (write_en && burst_cnt_reg == BCNT_W'(BURST_LEN-1))) begin
               state_next  = ARB;
               gnt_next    = '0;
               rr_ptr_next = inc_idx;
            end
         end
         default: state_next = IDLE;
      endcase
      // Window close overrides everything; a cut burst still moves the pointer on
      if (close_win) begin
         state_next = IDLE;
         gnt_next   = '0;
         if (state_reg == BURST) rr_ptr_next = inc_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         gnt_reg         <= '0;
         gnt_idx_reg     <= '0;
         rr_ptr_reg      <= '0;
         burst_cnt_reg   <= '0;
         vsync_d_reg     <= 1'b1;
         frame_tick_reg  <= 1'b0;
         frame_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         gnt_reg        <= gnt_next;
         gnt_idx_reg    <= gnt_idx_next;
         rr_ptr_reg     <= rr_ptr_next;
         burst_cnt_reg  <= burst_cnt_next;
         vsync_d_reg    <= vsync;
         frame_tick_reg <= open_win;
         if (open_win) frame_count_reg <= frame_count_reg + 1'b1;
      end
   end

   assign gnt         = timing_err ? '0 : gnt_reg;
   assign mem_we      = write_en;
   assign mem_addr    = (state_reg == BURST && !active) ? addr_arr[gnt_idx_reg] : render_addr;
   assign mem_wdata   = write_en ? data_arr[gnt_idx_reg] : '0;
   assign window      = in_win & ~active;
   assign frame_tick  = frame_tick_reg;
   assign frame_count = frame_count_reg;

`ifdef VBLANK_OVERRUN_STATS_EN
   logic                overrun_reg;
   logic [NUM_REQ-1:0]  overrun_mask_reg;
   logic [FCNT_W-1:0]   overrun_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_reg       <= 1'b0;
         overrun_mask_reg  <= '0;
         overrun_count_reg <= '0;
      end else if (open_win) begin
         overrun_reg      <= 1'b0;
         overrun_mask_reg <= '0;
      end else if (close_win && |req) begin
         overrun_reg      <= 1'b1;
         overrun_mask_reg <= req;
         if (overrun_count_reg != '1) overrun_count_reg <= overrun_count_reg + 1'b1;
      end
   end

   assign overrun       = overrun_reg;
   assign overrun_mask  = overrun_mask_reg;
   assign overrun_count = overrun_count_reg;
`endif

endmodule

// File: tb/tb_vblank_write_arbiter.sv
// Scoreboard bench for vblank_write_arbiter: modelled requesters, expected write
// order pushed per window, every RAM write popped and compared.
module tb_vblank_write_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 16;
   localparam int BURST_LEN = 8;
   localparam int FCNT_W    = 16;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      vsync = 1'b1;
   logic                      active = 1'b1;
   logic [NUM_REQ-1:0]        req = '0;
   logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data = '0;
   logic [NUM_REQ-1:0]        gnt;
   logic [ADDR_W-1:0]         render_addr = '0;
   logic [ADDR_W-1:0]         mem_addr;
   logic                      mem_we;
   logic [DATA_W-1:0]         mem_wdata;
   logic                      window;
   logic                      frame_tick;
   logic [FCNT_W-1:0]         frame_count;
`ifdef VBLANK_OVERRUN_STATS_EN
   logic                      overrun;
   logic [NUM_REQ-1:0]        overrun_mask;
   logic [FCNT_W-1:0]         overrun_count;
`endif

   vblank_write_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .BURST_LEN(BURST_LEN), .FCNT_W(FCNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vsync(vsync), .active(active),
      .req(req), .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
      .render_addr(render_addr), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .window(window), .frame_tick(frame_tick),
      .frame_count(frame_count)
`ifdef VBLANK_OVERRUN_STATS_EN
      , .overrun(overrun), .overrun_mask(overrun_mask), .overrun_count(overrun_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int                id;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                gap;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_wr = 0;
   int writes_seen = 0;
   int frames = 0;
   logic vsync_drv = 1'b1;
   logic active_drv = 1'b1;

   // requester stimulus state
   int                r_left [NUM_REQ];
   int                r_idx  [NUM_REQ];
   logic [ADDR_W-1:0] base_addr [NUM_REQ];
   logic [DATA_W-1:0] base_data [NUM_REQ];
   // reference model state
   int m_left [NUM_REQ];
   int m_next [NUM_REQ];
   int m_ptr = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         req[i] = (r_left[i] > 0);
         req_addr[i*ADDR_W +: ADDR_W] = base_addr[i] + ADDR_W'(r_idx[i]);
         req_data[i*DATA_W +: DATA_W] = base_data[i] + DATA_W'(r_idx[i]);
      end
   endtask

   task automatic load(input int id, input int n, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      r_left[id] = n;  r_idx[id] = 0;
      base_addr[id] = a;  base_data[id] = d;
      m_left[id] = n;  m_next[id] = 0;
   endtask

   task automatic push_words(input int id, input int n, input int gap_first);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.id   = id;
         e.addr = base_addr[id] + ADDR_W'(m_next[id]);
         e.data = base_data[id] + DATA_W'(m_next[id]);
         e.gap  = (k == 0) ? gap_first : 1;
         sb.push_back(e);
         m_next[id]++;
         m_left[id]--;
      end
   endtask

   // Expected write sequence for a window long enough to drain every requester
   task automatic expect_window();
      int  gap;
      bit  found;
      gap   = 0;
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         for (int k = 0; k < NUM_REQ && !found; k++) begin
            int i, n;
            i = (m_ptr + k) % NUM_REQ;
            if (m_left[i] > 0) begin
               found = 1'b1;
               n = (m_left[i] < BURST_LEN) ? m_left[i] : BURST_LEN;
               push_words(i, n, gap);
               gap   = (n == BURST_LEN) ? 2 : 3;
               m_ptr = (i + 1) % NUM_REQ;
            end
         end
      end
   endtask

   // One clock: handshake bookkeeping after the edge, output sampling at the negedge
   task automatic cycle();
      logic [NUM_REQ-1:0] hs;
      exp_t e;
      hs = gnt & req;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (hs[i]) begin
            r_left[i]--;
            r_idx[i]++;
         end
      end
      vsync  = vsync_drv;
      active = active_drv;
      drive_reqs();
      @(negedge clk);
      cyc++;
      if (mem_we) begin
         writes_seen++;
         if (sb.size() == 0) begin
            check_val("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            $display("write cyc=%0d req=%0d addr=%02h data=%04h", cyc, e.id, mem_addr, mem_wdata);
            check_val("wr_addr", 32'(mem_addr), 32'(e.addr));
            check_val("wr_data", 32'(mem_wdata), 32'(e.data));
            check_val("wr_gnt", 32'(gnt), 32'(1) << e.id);
            if (e.gap != 0) check_val("burst_gap", 32'(cyc - last_wr), 32'(e.gap));
         end
         last_wr = cyc;
      end
   endtask

   task automatic open_window();
      vsync_drv  = 1'b0;
      active_drv = 1'b0;
      cycle();
      check_val("win_on_fall_cycle", 32'(window), 32'd0);
      cycle();
      frames++;
      check_val("frame_tick_open", 32'(frame_tick), 32'd1);
      check_val("window_open", 32'(window), 32'd1);
      check_val("frame_count", 32'(frame_count), 32'(frames));
`ifdef VBLANK_OVERRUN_STATS_EN
      check_val("overrun_clr", 32'(overrun), 32'd0);
      check_val("overrun_mask_clr", 32'(overrun_mask), 32'd0);
`endif
      cycle();
      check_val("frame_tick_pulse", 32'(frame_tick), 32'd0);
   endtask

   task automatic close_window();
      vsync_drv = 1'b1;
      cycle();
      cycle();
      check_val("window_closed", 32'(window), 32'd0);
      check_val("gnt_closed", 32'(gnt), 32'd0);
      check_val("we_closed", 32'(mem_we), 32'd0);
      active_drv = 1'b1;
      cycle();
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((sb.size() != 0 || req != '0) && n < 400) begin
         cycle();
         n++;
      end
      if (n >= 400) check_val(tag, 32'(sb.size()), 32'd0);
      cycle();
      check_val("gnt_after_drain", 32'(gnt), 32'd0);
   endtask

   task automatic wait_writes(input int target, input string tag);
      int n;
      n = 0;
      while (writes_seen < target && n < 100) begin
         cycle();
         n++;
      end
      check_val(tag, 32'(writes_seen), 32'(target));
   endtask

   initial begin
      for (int i = 0; i < NUM_REQ; i++) load(i, 0, '0, '0);
      drive_reqs();
      render_addr = 8'h33;
      #12;
      check_val("rst_gnt", 32'(gnt), 32'd0);
      check_val("rst_we", 32'(mem_we), 32'd0);
      check_val("rst_wdata", 32'(mem_wdata), 32'd0);
      check_val("rst_window", 32'(window), 32'd0);
      check_val("rst_tick", 32'(frame_tick), 32'd0);
      check_val("rst_fcount", 32'(frame_count), 32'd0);
      check_val("rst_addr", 32'(mem_addr), 32'h33);
`ifdef VBLANK_OVERRUN_STATS_EN
      check_val("rst_overrun", 32'(overrun), 32'd0);
      check_val("rst_ocount", 32'(overrun_count), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);

      // Test 1: empty window, render address passthrough in IDLE
      render_addr = 8'hA5;
      #1;
      check_val("idle_render_addr", 32'(mem_addr), 32'hA5);
      render_addr = 8'h5A;
      #1;
      check_val("idle_render_addr2", 32'(mem_addr), 32'h5A);
      open_window();
      check_val("empty_gnt", 32'(gnt), 32'd0);
      close_window();

      // Test 2: single requester, three words, burst ends on req drop
      load(0, 3, 8'h10, 16'h00A0);
      expect_window();
      open_window();
      wait_drain("t2_drain_timeout");
      close_window();

      // Test 3: all four requesters, 20 words each, bursts capped at BURST_LEN
      for (int i = 0; i < NUM_REQ; i++) load(i, 20, ADDR_W'(i * 64), DATA_W'(16'h1000 * (i + 1)));
      expect_window();
      open_window();
      wait_drain("t3_drain_timeout");
      close_window();

      // Test 4: vsync rises after 5 words; 6th write lands on the rise cycle
      load(1, 10, 8'hC0, 16'h5100);
      load(2, 3, 8'h20, 16'h6200);
      push_words(1, 6, 0);
      m_ptr = 2;
      writes_seen = 0;
      open_window();
      wait_writes(5, "t4_five_writes");
      vsync_drv = 1'b1;
      cycle();
      check_val("rise_cycle_write", 32'(mem_we), 32'd1);
      check_val("rise_cycle_window", 32'(window), 32'd1);
      cycle();
      check_val("cut_window", 32'(window), 32'd0);
      check_val("cut_gnt", 32'(gnt), 32'd0);
      check_val("cut_we", 32'(mem_we), 32'd0);
`ifdef VBLANK_OVERRUN_STATS_EN
      check_val("overrun_set", 32'(overrun), 32'd1);
      check_val("overrun_mask", 32'(overrun_mask), 32'b0110);
      check_val("overrun_count1", 32'(overrun_count), 32'd1);
`endif
      active_drv = 1'b1;
      repeat (3) cycle();
      check_val("t4_no_extra_writes", 32'(writes_seen), 32'd6);

      // Next frame resumes arbitration past the cut requester
      expect_window();
      open_window();
      wait_drain("t4b_drain_timeout");
      close_window();

      // Test 5: active asserted inside the window during a burst
      load(3, 10, 8'h60, 16'h7300);
      push_words(3, 3, 0);
      writes_seen = 0;
      open_window();
      wait_writes(3, "t5_three_writes");
      active_drv = 1'b1;
      cycle();
      check_val("err_gnt", 32'(gnt), 32'd0);
      check_val("err_we", 32'(mem_we), 32'd0);
      check_val("err_window", 32'(window), 32'd0);
      cycle();
      check_val("err_idle_gnt", 32'(gnt), 32'd0);
`ifdef VBLANK_OVERRUN_STATS_EN
      check_val("overrun_mask2", 32'(overrun_mask), 32'b1000);
      check_val("overrun_count2", 32'(overrun_count), 32'd2);
`endif
      active_drv = 1'b0;
      cycle();
      cycle();
      check_val("err_stays_idle", 32'(window), 32'd0);
      check_val("t5_writes", 32'(writes_seen), 32'd3);
      vsync_drv  = 1'b1;
      active_drv = 1'b1;
      repeat (3) cycle();

      check_val("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
